mem_bus_arbiter: RTL and testbench

Two-master Wishbone classic arbiter that shares the single memory bus between the instruction-fetch port and the data port. The core-side interface unit drives the m0 (ibus) and m1 (dbus) ports; the slave port feeds the memory bus switch in front of the on-chip RAM. The arbiter uses round-robin grant. An optional watchdog terminates transfers that are never acknowledged.

---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/arb_watchdog.sv | 37 +++
 rtl/mem_bus_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master Wishbone memory bus arbiter.
package mem_arb_pkg;

  // Width of the watchdog cycle counter.
  localparam int ARB_TO_W = 16;

  // Arbiter FSM states.
  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Grant index values: which master owns the slave port.
  localparam logic GNT_M0 = 1'b0;
  localparam logic GNT_M1 = 1'b1;

  // Round-robin pick among pending masters; a tie goes to the one not served last.
  function automatic logic pick_grant(input logic m0_req, input logic m1_req, input logic last);
    logic pick;
    if (m0_req && m1_req) begin
      pick = (last == GNT_M0) ? GNT_M1 : GNT_M0;
    end else if (m1_req) begin
      pick = GNT_M1;
    end else begin
      pick = GNT_M0;
    end
    return pick;
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Transfer watchdog for mem_bus_arbiter: counts BUSY cycles without an
// acknowledge and flags expiry on the (TIMEOUT_CYCLES-1)th count.
// Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
module arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  input  logic ack,
  output logic expire
);

  localparam logic [ARB_TO_W-1:0] LIMIT = ARB_TO_W'(TIMEOUT_CYCLES - 1);

  logic [ARB_TO_W-1:0] count_r;

  // Cycle counter: held at zero outside a transfer, advances on each un-acked BUSY cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {ARB_TO_W{1'b0}};
    end else if (clear) begin
      count_r <= {ARB_TO_W{1'b0}};
    end else if (run && !ack) begin
      count_r <= count_r + ARB_TO_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // An ack in the expiry cycle completes the transfer normally, so it masks expiry.
  assign expire = run & ~ack & (count_r == LIMIT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master Wishbone classic arbiter (m0 = instruction fetch, m1 = data)
// sharing one memory bus with round-robin grant.
// Optional feature macro: MEM_ARB_TIMEOUT_EN enables the transfer watchdog
// (arb_watchdog); without it both err outputs are tied low.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i
);

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
    $error("mem_bus_arbiter: TIMEOUT_CYCLES must be in 1..65535");
  end

  arb_state_e state_r, state_nxt_s;
  logic       grant_r, grant_nxt_s;
  logic       last_r, last_nxt_s;
  logic       gnt_stb_s;
  logic       expire_s;

  assign gnt_stb_s = (grant_r == GNT_M1) ? m1_stb_i : m0_stb_i;

`ifdef MEM_ARB_TIMEOUT_EN
  arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk_i),
    .rst    (rst_i),
    .clear  (state_r == ARB_IDLE),
    .run    (state_r == ARB_BUSY),
    .ack    (s_ack_i),
    .expire (expire_s)
  );
`else
  assign expire_s = 1'b0;
`endif

  // Next-state, grant and round-robin history decisions.
  always_comb begin
    state_nxt_s = state_r;
    grant_nxt_s = grant_r;
    last_nxt_s  = last_r;
    case (state_r)
      ARB_IDLE: begin
        if (m0_stb_i || m1_stb_i) begin
          grant_nxt_s = pick_grant(m0_stb_i, m1_stb_i, last_r);
          state_nxt_s = ARB_BUSY;
        end else begin
          state_nxt_s = ARB_IDLE;
        end
      end
      ARB_BUSY: begin
        // Ack beats both a simultaneous abort and a watchdog expiry.
        if (s_ack_i || expire_s) begin
          state_nxt_s = ARB_IDLE;
          last_nxt_s  = grant_r;
        end else if (!gnt_stb_s) begin
          // Master abort: give the bus back without counting it as served.
          state_nxt_s = ARB_IDLE;
        end else begin
          state_nxt_s = ARB_BUSY;
        end
      end
      default: begin
        state_nxt_s = ARB_IDLE;
      end
    endcase
  end

  // FSM, grant and last-served registers; m0 wins the first tie after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ARB_IDLE;
      grant_r <= GNT_M0;
      last_r  <= GNT_M1;
    end else begin
      state_r <= state_nxt_s;
      grant_r <= grant_nxt_s;
      last_r  <= last_nxt_s;
    end
  end

  // Slave-port mux and master handshakes, combinational from the current grant.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = 32'h0000_0000;
    s_dat_o  = 32'h0000_0000;
    s_sel_o  = 4'h0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_err_o = 1'b0;
    if (state_r == ARB_BUSY) begin
      s_cyc_o = gnt_stb_s & ~expire_s;
      s_stb_o = gnt_stb_s & ~expire_s;
      if (grant_r == GNT_M1) begin
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        m1_ack_o = s_ack_i;
        m1_err_o = expire_s;
      end else begin
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        m0_ack_o = s_ack_i;
        m0_err_o = expire_s;
      end
    end else begin
      s_cyc_o = 1'b0;
    end
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (TIMEOUT_CYCLES = 4).
module tb_mem_bus_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m0_stb_i, m0_we_i, m1_stb_i, m1_we_i;
  logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
    .m0_sel_i(m0_sel_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
    .m1_sel_i(m1_sel_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic reset_dut();
    rst_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    s_dat_i = 32'h1234_5678;
    #12;
    checks++; if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL rst_cyc got %b exp 0", s_cyc_o); end
    checks++; if (s_stb_o !== 1'b0) begin errors++; $display("FAIL rst_stb got %b exp 0", s_stb_o); end
    checks++; if (s_we_o !== 1'b0) begin errors++; $display("FAIL rst_we got %b exp 0", s_we_o); end
    checks++; if (s_adr_o !== 32'h0) begin errors++; $display("FAIL rst_adr got %h exp 0", s_adr_o); end
    checks++; if (s_sel_o !== 4'h0) begin errors++; $display("FAIL rst_sel got %h exp 0", s_sel_o); end
    checks++; if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 4'b0000) begin errors++; $display("FAIL rst_ackerr got %b exp 0000", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}); end
    checks++; if (m0_dat_o !== 32'h1234_5678) begin errors++; $display("FAIL rst_m0_dat got %h exp 12345678", m0_dat_o); end
    checks++; if (m1_dat_o !== 32'h1234_5678) begin errors++; $display("FAIL rst_m1_dat got %h exp 12345678", m1_dat_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_idle_ack();
    s_ack_i = 1'b1;
    #1;
    checks++; if ({m0_ack_o, m1_ack_o} !== 2'b00) begin errors++; $display("FAIL idle_ack got %b exp 00", {m0_ack_o, m1_ack_o}); end
    tick();
    @(negedge clk_i);
    checks++; if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL idle_ack_cyc got %b exp 0", s_cyc_o); end
    s_ack_i = 1'b0;
  endtask

  task automatic test_single_read();
    tick();
    m0_stb_i = 1'b1; m0_we_i = 1'b0; m0_adr_i = 32'h0000_0100; m0_sel_i = 4'hF;
    @(negedge clk_i);
    checks++; if (s_stb_o !== 1'b0) begin errors++; $display("FAIL rd_stb_early got %b exp 0", s_stb_o); end
    tick();
    @(negedge clk_i);
    checks++; if (s_stb_o !== 1'b1) begin errors++; $display("FAIL rd_stb got %b exp 1", s_stb_o); end
    checks++; if (s_adr_o !== 32'h0000_0100) begin errors++; $display("FAIL rd_adr got %h exp 00000100", s_adr_o); end
    checks++; if (m0_ack_o !== 1'b0) begin errors++; $display("FAIL rd_ack_early got %b exp 0", m0_ack_o); end
    tick();
    @(negedge clk_i);
    checks++; if (m0_ack_o !== 1'b0) begin errors++; $display("FAIL rd_ack_wait got %b exp 0", m0_ack_o); end
    tick();
    s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
    @(negedge clk_i);
    checks++; if (m0_ack_o !== 1'b1) begin errors++; $display("FAIL rd_ack got %b exp 1", m0_ack_o); end
    checks++; if (m1_ack_o !== 1'b0) begin errors++; $display("FAIL rd_m1_ack got %b exp 0", m1_ack_o); end
    checks++; if (m0_dat_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_dat got %h exp deadbeef", m0_dat_o); end
    tick();
    s_ack_i = 1'b0; m0_stb_i = 1'b0;
    @(negedge clk_i);
    checks++; if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL rd_idle_cyc got %b exp 0", s_cyc_o); end
  endtask

  task automatic test_simultaneous();
    reset_dut();
    tick();
    m0_stb_i = 1'b1; m0_we_i = 1'b1; m0_adr_i = 32'h10; m0_dat_i = 32'hA5A5_A5A5; m0_sel_i = 4'hF;
    m1_stb_i = 1'b1; m1_we_i = 1'b0; m1_adr_i = 32'h20; m1_sel_i = 4'h3;
    @(negedge clk_i);
    checks++; if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL sim_idle got %b exp 0", s_cyc_o); end
    tick();
    s_ack_i = 1'b1;
    @(negedge clk_i);
    checks++; if (s_we_o !== 1'b1) begin errors++; $display("FAIL sim_m0_we got %b exp 1", s_we_o); end
    checks++; if (s_adr_o !== 32'h10) begin errors++; $display("FAIL sim_m0_adr got %h exp 10", s_adr_o); end
    checks++; if (s_dat_o !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sim_m0_dat got %h exp a5a5a5a5", s_dat_o); end
    checks++; if ({m0_ack_o, m1_ack_o} !== 2'b10) begin errors++; $display("FAIL sim_m0_ack got %b exp 10", {m0_ack_o, m1_ack_o}); end
    tick();
    m0_stb_i = 1'b0; m0_we_i = 1'b0; s_ack_i = 1'b0;
    @(negedge clk_i);
    checks++; if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL sim_gap_cyc got %b exp 0", s_cyc_o); end
    checks++; if (s_adr_o !== 32'h0) begin errors++; $display("FAIL sim_gap_adr got %h exp 0", s_adr_o); end
    tick();
    s_ack_i = 1'b1;
    @(negedge clk_i);
    checks++; if (s_adr_o !== 32'h20) begin errors++; $display("FAIL sim_m1_adr got %h exp 20", s_adr_o); end
    checks++; if (s_we_o !== 1'b0) begin errors++; $display("FAIL sim_m1_we got %b exp 0", s_we_o); end
    checks++; if (s_sel_o !== 4'h3) begin errors++; $display("FAIL sim_m1_sel got %h exp 3", s_sel_o); end
    checks++; if ({m0_ack_o, m1_ack_o} !== 2'b01) begin errors++; $display("FAIL sim_m1_ack got %b exp 01", {m0_ack_o, m1_ack_o}); end
    tick();
    m1_stb_i = 1'b0; s_ack_i = 1'b0;
  endtask

  task automatic test_round_robin();
    logic exp_m1;
    tick();
    m0_stb_i = 1'b1; m0_adr_i = 32'h0000_1000;
    m1_stb_i = 1'b1; m1_adr_i = 32'h0000_2000;
    for (int i = 0; i < 6; i++) begin
      exp_m1 = (i % 2) == 1;
      @(negedge clk_i);
      checks++; if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL rr_gap%0d got %b exp 0", i, s_cyc_o); end
      tick();
      s_ack_i = 1'b1;
      @(negedge clk_i);
      checks++; if ({m0_ack_o, m1_ack_o} !== {~exp_m1, exp_m1}) begin errors++; $display("FAIL rr_ack%0d got %b exp %b", i, {m0_ack_o, m1_ack_o}, {~exp_m1, exp_m1}); end
      checks++; if (s_adr_o !== (exp_m1 ? 32'h0000_2000 : 32'h0000_1000)) begin errors++; $display("FAIL rr_adr%0d got %h", i, s_adr_o); end
      tick();
      s_ack_i = 1'b0;
    end
    m0_stb_i = 1'b0; m1_stb_i = 1'b0;
  endtask

  task automatic test_abort();
    // m0 transfer first so m0 is the last-served master.
    m0_stb_i = 1'b1; m0_adr_i = 32'h0000_0300;
    tick();
    s_ack_i = 1'b1;
    @(negedge clk_i);
    checks++; if (m0_ack_o !== 1'b1) begin errors++; $display("FAIL ab_pre_ack got %b exp 1", m0_ack_o); end
    tick();
    m0_stb_i = 1'b0; s_ack_i = 1'b0; m1_stb_i = 1'b1; m1_adr_i = 32'h0000_0400;
    tick();
    m0_stb_i = 1'b1;
    @(negedge clk_i);
    checks++; if (s_adr_o !== 32'h0000_0400) begin errors++; $display("FAIL ab_m1_adr got %h exp 00000400", s_adr_o); end
    tick();
    m1_stb_i = 1'b0;
    @(negedge clk_i);
    checks++; if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL ab_cyc_drop got %b exp 0", s_cyc_o); end
    checks++; if (m1_ack_o !== 1'b0) begin errors++; $display("FAIL ab_m1_ack got %b exp 0", m1_ack_o); end
    tick();
    @(negedge clk_i);
    checks++; if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL ab_idle got %b exp 0", s_cyc_o); end
    tick();
    s_ack_i = 1'b1;
    @(negedge clk_i);
    checks++; if (s_adr_o !== 32'h0000_0300) begin errors++; $display("FAIL ab_m0_next got %h exp 00000300", s_adr_o); end
    checks++; if (m0_ack_o !== 1'b1) begin errors++; $display("FAIL ab_m0_ack got %b exp 1", m0_ack_o); end
    tick();
    m0_stb_i = 1'b0; s_ack_i = 1'b0; m1_stb_i = 1'b1;
    // Abort m1 again; history must stay at m0 so the following tie goes to m1.
    tick();
    m1_stb_i = 1'b0;
    @(negedge clk_i);
    checks++; if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL ab2_cyc got %b exp 0", s_cyc_o); end
    tick();
    m0_stb_i = 1'b1; m1_stb_i = 1'b1;
    tick();
    s_ack_i = 1'b1;
    @(negedge clk_i);
    checks++; if (s_adr_o !== 32'h0000_0400) begin errors++; $display("FAIL ab2_tie_adr got %h exp 00000400", s_adr_o); end
    checks++; if ({m0_ack_o, m1_ack_o} !== 2'b01) begin errors++; $display("FAIL ab2_tie_ack got %b exp 01", {m0_ack_o, m1_ack_o}); end
    tick();
    m0_stb_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0;
  endtask

  task automatic test_watchdog();
    m0_stb_i = 1'b1; m0_adr_i = 32'h0000_0500;
`ifdef MEM_ARB_TIMEOUT_EN
    for (int c = 1; c <= 4; c++) begin
      tick();
      @(negedge clk_i);
      checks++; if (m0_err_o !== (c == 4)) begin errors++; $display("FAIL wd_err_c%0d got %b exp %b", c, m0_err_o, (c == 4)); end
      checks++; if (s_cyc_o !== (c != 4)) begin errors++; $display("FAIL wd_cyc_c%0d got %b exp %b", c, s_cyc_o, (c != 4)); end
      checks++; if (m1_err_o !== 1'b0) begin errors++; $display("FAIL wd_m1_err_c%0d got %b exp 0", c, m1_err_o); end
    end
    tick();
    m0_stb_i = 1'b0;
    @(negedge clk_i);
    checks++; if (m0_err_o !== 1'b0) begin errors++; $display("FAIL wd_err_after got %b exp 0", m0_err_o); end
    checks++; if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL wd_idle got %b exp 0", s_cyc_o); end
`else
    for (int c = 1; c <= 300; c++) begin
      tick();
      @(negedge clk_i);
      checks++; if ({m0_err_o, m1_err_o} !== 2'b00) begin errors++; $display("FAIL nowd_err_c%0d got %b exp 00", c, {m0_err_o, m1_err_o}); end
    end
    checks++; if (s_cyc_o !== 1'b1) begin errors++; $display("FAIL nowd_busy got %b exp 1", s_cyc_o); end
    tick();
    m0_stb_i = 1'b0;
    tick();
`endif
  endtask

  task automatic test_async_reset();
    m1_stb_i = 1'b1; m1_adr_i = 32'h0000_0600;
    tick();
    @(negedge clk_i);
    checks++; if (s_cyc_o !== 1'b1) begin errors++; $display("FAIL ar_busy got %b exp 1", s_cyc_o); end
    #2;
    rst_i = 1'b1; s_ack_i = 1'b1;
    #1;
    checks++; if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000) begin errors++; $display("FAIL ar_ctl got %b exp 000", {s_cyc_o, s_stb_o, s_we_o}); end
    checks++; if (s_adr_o !== 32'h0) begin errors++; $display("FAIL ar_adr got %h exp 0", s_adr_o); end
    checks++; if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 4'b0000) begin errors++; $display("FAIL ar_ackerr got %b exp 0000", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}); end
    m0_stb_i = 1'b1; m0_adr_i = 32'h0000_0700;
    @(negedge clk_i);
    rst_i = 1'b0;
    tick();
    @(negedge clk_i);
    checks++; if (s_adr_o !== 32'h0000_0700) begin errors++; $display("FAIL ar_tie_adr got %h exp 00000700", s_adr_o); end
    checks++; if ({m0_ack_o, m1_ack_o} !== 2'b10) begin errors++; $display("FAIL ar_tie_ack got %b exp 10", {m0_ack_o, m1_ack_o}); end
    tick();
    m0_stb_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    m0_stb_i = 1'b0; m0_we_i = 1'b0; m0_adr_i = 32'h0; m0_dat_i = 32'h0; m0_sel_i = 4'h0;
    m1_stb_i = 1'b0; m1_we_i = 1'b0; m1_adr_i = 32'h0; m1_dat_i = 32'h0; m1_sel_i = 4'h0;
    s_dat_i = 32'h0; s_ack_i = 1'b0;
    test_reset();
    test_idle_ack();
    test_single_read();
    test_simultaneous();
    test_round_robin();
    test_abort();
    test_watchdog();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached");
    $fatal(1, "bench did not complete");
  end

endmodule
